// File: rtl/sample_osc.sv
// rtl/sample_osc.sv - phase-accumulator oscillator driven by the rate divider's sample tick
// Stage 1 accumulates phase on each enabled tick; stage 2 shapes the phase into one sample.
module sample_osc #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             en,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [1:0]       wave_sel,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             wrap
);

  localparam logic [1:0] SEL_SQUARE = 2'b00;
  localparam logic [1:0] SEL_SAW    = 2'b01;
  localparam logic [1:0] SEL_TRI    = 2'b10;
  localparam logic [1:0] SEL_SILENT = 2'b11;

  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0] r_phase;
  logic [1:0]       r_active_sel;
  logic             r_tick_d;
  logic             r_carry_d;
  logic [OUT_W-1:0] r_sample;
  logic             r_sample_valid;
  logic             r_wrap;

  logic [ACC_W:0]   w_sum;
  logic [OUT_W-1:0] w_shape;

  assign w_sum = {1'b0, r_phase} + {1'b0, freq_word};

  // Shaping reads the phase and selection committed on the previous edge.
  always_comb begin
    w_shape = MIDSCALE;
    case (r_active_sel)
      SEL_SQUARE: w_shape = r_phase[ACC_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      SEL_SAW:    w_shape = r_phase[ACC_W-1 -: OUT_W];
      SEL_TRI:    w_shape = r_phase[ACC_W-1] ? ~r_phase[ACC_W-2 -: OUT_W]
                                             :  r_phase[ACC_W-2 -: OUT_W];
      SEL_SILENT: w_shape = MIDSCALE;
      default:    w_shape = MIDSCALE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase        <= '0;
      r_active_sel   <= SEL_SILENT;
      r_tick_d       <= 1'b0;
      r_carry_d      <= 1'b0;
      r_sample       <= MIDSCALE;
      r_sample_valid <= 1'b0;
      r_wrap         <= 1'b0;
    end else begin
      // While stopped the selection follows the request directly.
      if (!en) begin
        r_active_sel <= wave_sel;
        r_tick_d     <= 1'b0;
        r_carry_d    <= 1'b0;
      end else if (pulse) begin
        r_phase   <= w_sum[ACC_W-1:0];
        r_carry_d <= w_sum[ACC_W];
        r_tick_d  <= 1'b1;
        if (w_sum[ACC_W]) begin
          r_active_sel <= wave_sel;
        end
      end else begin
        r_tick_d  <= 1'b0;
        r_carry_d <= 1'b0;
      end

      if (r_tick_d) begin
        r_sample       <= w_shape;
        r_sample_valid <= 1'b1;
        r_wrap         <= r_carry_d;
      end else begin
        r_sample_valid <= 1'b0;
        r_wrap         <= 1'b0;
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign wrap         = r_wrap;

endmodule

// File: tb/tb_sample_osc.sv
// tb/tb_sample_osc.sv - self-checking bench for sample_osc
// A transaction-level model predicts each sample; directed tests pin literal values.
module tb_sample_osc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse = 1'b0;
  logic        en = 1'b0;
  logic [15:0] freq_word = 16'h0;
  logic [1:0]  wave_sel = 2'b11;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  sample_osc #(.ACC_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .en(en), .freq_word(freq_word),
    .wave_sel(wave_sel), .sample(sample), .sample_valid(sample_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int shape(input int p, input int sel);
    case (sel)
      0:       return (p >= 32768) ? 255 : 0;
      1:       return p / 256;
      2:       return (p < 32768) ? (p / 128) % 256 : 255 - ((p / 128) % 256);
      default: return 128;
    endcase
  endfunction

  typedef struct {int due; int s; bit w;} exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   m_phase = 0;
  int   m_sel = 3;
  int   m_last = 128;

  always @(posedge clk) begin
    int sum;
    exp_t e;
    cyc++;
    if (rst) begin
      m_phase = 0;
      m_sel   = 3;
      m_last  = 128;
      q.delete();
    end else if (!en) begin
      m_sel = wave_sel;
    end else if (pulse) begin
      sum     = m_phase + int'(freq_word);
      m_phase = sum % 65536;
      if (sum >= 65536) m_sel = wave_sel;
      e.due = cyc + 1;
      e.s   = shape(m_phase, m_sel);
      e.w   = (sum >= 65536);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("model_valid", sample_valid, 1);
        check("model_sample", sample, q[0].s);
        check("model_wrap", wrap, q[0].w);
        m_last = q[0].s;
        void'(q.pop_front());
      end else begin
        check("model_idle_valid", sample_valid, 0);
        check("model_idle_wrap", wrap, 0);
        check("model_hold_sample", sample, m_last);
      end
    end
  end

  task automatic setup(input logic [1:0] sel, input logic [15:0] fw);
    @(negedge clk); rst = 1'b1; pulse = 1'b0; en = 1'b1;
    @(negedge clk); rst = 1'b0; en = 1'b0; wave_sel = sel;
    @(negedge clk); en = 1'b1; freq_word = fw;
  endtask

  task automatic run_pulse(input string name, input int exp_s, input bit exp_w, input int gap);
    @(negedge clk); pulse = 1'b1;
    @(negedge clk); pulse = 1'b0;
    check({name, "_early"}, sample_valid, 0);
    @(negedge clk);
    check({name, "_valid"}, sample_valid, 1);
    check({name, "_sample"}, sample, exp_s);
    check({name, "_wrap"}, wrap, exp_w);
    repeat (gap) @(negedge clk);
  endtask

  logic [7:0] tri_exp [8];
  logic [7:0] sq_exp  [8];

  initial begin
    tri_exp = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00};
    sq_exp  = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    // reset held with pulse toggling
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); pulse = (k == 0); en = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin rst = 1'b0; pulse = 1'b0; en = 1'b0; end
      check("reset_sample", sample, 8'h80);
      check("reset_valid", sample_valid, 0);
      check("reset_wrap", wrap, 0);
    end

    setup(2'b01, 16'h1000);
    for (int i = 1; i <= 16; i++)
      run_pulse("saw", (i * 16) % 256, (i == 16), 97);

    setup(2'b10, 16'h2000);
    for (int i = 0; i < 8; i++)
      run_pulse("tri", tri_exp[i], (i == 7), 6);

    setup(2'b00, 16'h2000);
    for (int i = 0; i < 8; i++)
      run_pulse("square", sq_exp[i], (i == 7), 6);

    // deferred select: square requested mid-period only lands at the wrap
    setup(2'b01, 16'h1000);
    for (int i = 1; i <= 17; i++) begin
      if (i == 5) wave_sel = 2'b00;
      run_pulse("defer", (i <= 15) ? i * 16 : 0, (i == 16), 3);
    end

    // hold: phase is 0x1000, pulses ignored while stopped
    @(negedge clk); en = 1'b0; wave_sel = 2'b01;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); pulse = k[0];
      check("hold_valid", sample_valid, 0);
    end
    pulse = 1'b0;
    @(negedge clk); en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_valid", sample_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("b2b_sample", sample, 8'h20 + 8'h10 * (k - 2));
      pulse = (k < 4);
    end
    pulse = 1'b0;
    repeat (3) @(negedge clk);

    // reset on the same edge as a pulse
    @(negedge clk); pulse = 1'b1; rst = 1'b1;
    @(negedge clk); pulse = 1'b0; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("coll_same_valid", sample_valid, 0);
      check("coll_same_sample", sample, 8'h80);
    end
    run_pulse("coll_same_silent", 8'h80, 0, 2);
    @(negedge clk); en = 1'b0; wave_sel = 2'b01;
    @(negedge clk); en = 1'b1;
    run_pulse("coll_same_phase", 8'h20, 0, 2);

    // reset one cycle after a pulse
    @(negedge clk); pulse = 1'b1;
    @(negedge clk); pulse = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; en = 1'b0; wave_sel = 2'b01;
    for (int k = 0; k < 3; k++) begin
      check("coll_late_valid", sample_valid, 0);
      check("coll_late_sample", sample, 8'h80);
      @(negedge clk); en = 1'b1;
    end
    run_pulse("coll_late_phase", 8'h10, 0, 2);

    // zero frequency still produces a sample per tick
    freq_word = 16'h0;
    run_pulse("fw0_a", 8'h10, 0, 1);
    run_pulse("fw0_b", 8'h10, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
